addsub_serial: RTL

- Parametrised, multi-cycle two's-complement adder/subtractor. Processes a WIDTH-bit operand pair DIGIT bits per clock, LSB digit first.
- Successor to the 1-bit full add/sub cell. The s_op semantics are unchanged: b is XORed with s_op, and s_op also drives the carry-in.
- Adds a start/busy/done handshake, a registered result, carry-out and signed-overflow flags.
- Sits as a small-area arithmetic unit wherever throughput can be traded for gates.

---
 rtl/addsub_pkg.sv | 15 +
 rtl/addsub_digit.sv | 42 ++++
 rtl/addsub_serial.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/addsub_pkg.sv
// Shared definitions for the serial add/subtract unit.
//   state_t : controller states (IDLE, RUN, DONE)
//   OP_ADD / OP_SUB : encoding of the s_op input
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/addsub_digit.sv
// Combinational DIGIT-bit ripple add/subtract slice.
// Each bit is a full-adder cell whose B input is XORed with s_op, so
// with s_op=1 and c_in=1 the slice computes a - b (two's complement).
// Ports:
//   a_d      in  DIGIT  operand A digit
//   b_d      in  DIGIT  operand B digit (inverted internally when s_op=1)
//   s_op     in  1      0 = add, 1 = subtract
//   c_in     in  1      carry into bit 0 of the digit
//   s_d      out DIGIT  sum digit
//   c_out    out 1      carry out of the top bit of the digit
//   c_msb_in out 1      carry into the top bit (for signed overflow)
module addsub_digit #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] a_d,
    input  logic [DIGIT-1:0] b_d,
    input  logic             s_op,
    input  logic             c_in,
    output logic [DIGIT-1:0] s_d,
    output logic             c_out,
    output logic             c_msb_in
);

    logic [DIGIT:0] w_c;

    assign w_c[0] = c_in;

    generate
        for (genvar gi = 0; gi < DIGIT; gi++) begin : g_fa
            logic w_bx;
            logic w_p;
            assign w_bx        = b_d[gi] ^ s_op;
            assign w_p         = a_d[gi] ^ w_bx;
            assign s_d[gi]     = w_p ^ w_c[gi];
            assign w_c[gi + 1] = (a_d[gi] & w_bx) | (w_c[gi] & w_p);
        end
    endgenerate

    assign c_out    = w_c[DIGIT];
    assign c_msb_in = w_c[DIGIT-1];

endmodule

// File: rtl/addsub_serial.sv
// Multi-cycle two's-complement adder/subtractor. A WIDTH-bit operand pair
// is processed DIGIT bits per clock, least significant digit first, taking
// N = WIDTH/DIGIT RUN cycles followed by a one-cycle DONE.
// Optional build macro ADDSUB_SAT_EN: when defined, an overflowing result
// saturates to the most positive / most negative value; otherwise it wraps.
// Ports:
//   clk    in  1      clock, rising edge
//   rst_n  in  1      asynchronous active-low reset
//   start  in  1      request, sampled in IDLE or DONE only
//   a, b   in  WIDTH  operands, captured on an accepted start
//   cin    in  1      carry-in (add) / borrow-in (subtract)
//   s_op   in  1      0 = a+b+cin, 1 = a-b-cin
//   busy   out 1      high while digits are being processed
//   done   out 1      one-cycle pulse when result/flags update
//   result out WIDTH  sum or difference, held until next completion
//   cout   out 1      raw carry out of the MSB (subtract: 1 = no borrow)
//   ovf    out 1      signed overflow
// WIDTH must be at least 2 and a multiple of DIGIT.
module addsub_serial
    import addsub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             s_op,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

    state_t r_state;
    state_t w_state_next;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_sop;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_result;
    logic             r_cout;
    logic             r_ovf;

    logic             w_accept;
    logic             w_last;
    logic [DIGIT-1:0] w_s_d;
    logic             w_c_out;
    logic             w_c_msb_in;
    logic             w_ovf;
    logic [WIDTH-1:0] w_sum_next;
    logic [WIDTH-1:0] w_result_next;

    // A request is honoured in IDLE and in DONE (back-to-back); never in RUN.
    assign w_accept = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_last   = (r_state == RUN) && (r_cnt == LAST_CNT);

    addsub_digit #(
        .DIGIT (DIGIT)
    ) u_digit (
        .a_d      (r_a[DIGIT-1:0]),
        .b_d      (r_b[DIGIT-1:0]),
        .s_op     (r_sop),
        .c_in     (r_carry),
        .s_d      (w_s_d),
        .c_out    (w_c_out),
        .c_msb_in (w_c_msb_in)
    );

    // New digits enter at the top of the sum register and move down, so after
    // N digits the first (least significant) digit sits at bit 0.
    generate
        if (N == 1) begin : g_sum_single
            assign w_sum_next = w_s_d;
        end else begin : g_sum_shift
            assign w_sum_next = {w_s_d, r_sum[WIDTH-1:DIGIT]};
        end
    endgenerate

    // Only meaningful on the final digit, where the slice top bit is the MSB.
    assign w_ovf = w_c_out ^ w_c_msb_in;

`ifdef ADDSUB_SAT_EN
    // On the final digit the operand register has shifted the top digit of A
    // down to the bottom, so r_a[DIGIT-1] is A's sign bit. When overflow
    // occurs the true result has the sign of A.
    always_comb begin
        w_result_next = w_sum_next;
        if (w_ovf) begin
            if (r_a[DIGIT-1]) begin
                w_result_next = {1'b1, {(WIDTH-1){1'b0}}};
            end else begin
                w_result_next = {1'b0, {(WIDTH-1){1'b1}}};
            end
        end
    end
`else
    assign w_result_next = w_sum_next;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                if (r_cnt == LAST_CNT) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    w_state_next = RUN;
                end else begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Datapath: operand capture, digit shifting, carry, counter, result/flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_sum    <= '0;
            r_sop    <= 1'b0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
            r_result <= '0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= b;
            r_sop   <= s_op;
            // Subtract is a + ~b + 1 - borrow, hence the carry seed cin ^ s_op.
            r_carry <= cin ^ s_op;
            r_cnt   <= '0;
        end else if (r_state == RUN) begin
            r_a     <= r_a >> DIGIT;
            r_b     <= r_b >> DIGIT;
            r_sum   <= w_sum_next;
            r_carry <= w_c_out;
            r_cnt   <= r_cnt + 1'b1;
            if (w_last) begin
                r_result <= w_result_next;
                r_cout   <= w_c_out;
                r_ovf    <= w_ovf;
            end
        end
    end

    assign busy   = (r_state == RUN);
    assign done   = (r_state == DONE);
    assign result = r_result;
    assign cout   = r_cout;
    assign ovf    = r_ovf;

endmodule
